idct_2d_sequencer: RTL and testbench

Sequencer that performs a full 8x8 two-dimensional inverse DCT by time-sharing the one 8-lane 1-D IDCT array (`IDCT_top`) across a row pass and a column pass. It accepts one 64-coefficient block from the dequantiser side and issues it to the array with the row shift. It then transposes the array result, re-issues it with the column shift, and transposes the final result. The block sits between coefficient dequantisation and colour conversion and owns the array's `s_valid`, `data_in` and `shift_amount`.

---
 rtl/idct_2d_sequencer.sv | 155 +++++++++++++++
 tb/tb_idct_2d_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_2d_sequencer.sv
// Two-pass 8x8 IDCT sequencer: time-shares one 1-D IDCT array over row and column passes.
// Optional watchdog compiled in with `define IDCT_SEQ_WATCHDOG_EN.
module idct_2d_sequencer #(
    parameter int unsigned ROW_SHIFT = 11,
    parameter int unsigned COL_SHIFT = 20,
    parameter int unsigned WD_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [2047:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [2047:0] m_data,
    output logic          idct_valid,
    output logic [4:0]    idct_shift,
    output logic [2047:0] idct_data,
    input  logic          idct_done,
    input  logic [2047:0] idct_result,
    output logic          err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ROW_ISSUE = 3'd1;
    localparam logic [2:0] S_ROW_WAIT  = 3'd2;
    localparam logic [2:0] S_COL_ISSUE = 3'd3;
    localparam logic [2:0] S_COL_WAIT  = 3'd4;
    localparam logic [2:0] S_OUT       = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [2047:0] work_q, work_d;
    logic [2047:0] out_q, out_d;
    logic [4:0]    shift_q, shift_d;
    logic          s_ready_q, s_ready_d;
    logic          timeout;

    // Element (r,c) moves to (c,r); pure rewiring of 32-bit lanes.
    function automatic logic [2047:0] transpose8(input logic [2047:0] blk);
        logic [2047:0] t;
        t = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                t[(c*8+r)*32 +: 32] = blk[(r*8+c)*32 +: 32];
            end
        end
        return t;
    endfunction

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (s_valid && s_ready_q) begin
                    work_d  = s_data;
                    shift_d = 5'(ROW_SHIFT);
                    state_d = S_ROW_ISSUE;
                end
            end
            S_ROW_ISSUE: state_d = S_ROW_WAIT;
            S_ROW_WAIT: begin
                if (idct_done) begin
                    work_d  = transpose8(idct_result);
                    shift_d = 5'(COL_SHIFT);
                    state_d = S_COL_ISSUE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_COL_ISSUE: state_d = S_COL_WAIT;
            S_COL_WAIT: begin
                if (idct_done) begin
                    out_d   = transpose8(idct_result);
                    state_d = S_OUT;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registered so that s_ready stays low while reset is asserted.
        s_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            work_q    <= '0;
            out_q     <= '0;
            shift_q   <= 5'(ROW_SHIFT);
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            out_q     <= out_d;
            shift_q   <= shift_d;
            s_ready_q <= s_ready_d;
        end
    end

`ifdef IDCT_SEQ_WATCHDOG_EN
    localparam int WD_W = ($clog2(WD_CYCLES + 1) > 8) ? $clog2(WD_CYCLES + 1) : 8;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    always_comb begin
        wd_d    = wd_q;
        err_d   = err_q;
        timeout = 1'b0;
        if (state_q == S_ROW_ISSUE || state_q == S_COL_ISSUE) begin
            wd_d = '0;
        end else if (state_q == S_ROW_WAIT || state_q == S_COL_WAIT) begin
            wd_d = wd_q + 1'b1;
            // A result arriving on the expiry cycle still wins.
            if (!idct_done && wd_d == WD_W'(WD_CYCLES)) begin
                timeout = 1'b1;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    // Always 0; the comparison only keeps WD_CYCLES referenced in this build.
    assign err     = (WD_CYCLES == 0) && 1'b0;
`endif

    assign s_ready    = s_ready_q;
    assign m_valid    = (state_q == S_OUT);
    assign m_data     = out_q;
    assign idct_valid = (state_q == S_ROW_ISSUE) || (state_q == S_COL_ISSUE);
    assign idct_shift = shift_q;
    assign idct_data  = work_q;

endmodule

// File: tb/tb_idct_2d_sequencer.sv
// Bench for idct_2d_sequencer: stub 1-D array with latency L, table-driven blocks and a scoreboard.
module tb_idct_2d_sequencer;

    localparam int L    = 4;
    localparam int ROW  = 11;
    localparam int COL  = 20;
    localparam int WD   = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [2047:0] s_data = '0;
    logic          s_ready, m_valid, idct_valid, idct_done, err;
    logic [2047:0] m_data, idct_data;
    logic [4:0]    idct_shift;

    logic          extra_done = 1'b0;
    bit            stub_en = 1'b1;
    int            stub_mode = 0;
    logic [L-1:0]  vpipe;
    logic [2047:0] stub_res = '0;
    logic [4:0]    shift_at [2];
    int            issue_n;
    int            cyc = 0;

    int compared = 0;
    int mismatched = 0;

    logic [2047:0] exp_q [$];

    typedef struct {
        logic [2047:0] blk;
        int            mode;
        int            delay;
        bit            inject;
        logic [2047:0] exp;
    } vec_t;

    vec_t vecs [5];

    idct_2d_sequencer #(
        .ROW_SHIFT(ROW),
        .COL_SHIFT(COL),
        .WD_CYCLES(WD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .idct_valid (idct_valid),
        .idct_shift (idct_shift),
        .idct_data  (idct_data),
        .idct_done  (idct_done),
        .idct_result(stub_res),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2047:0] tr(input logic [2047:0] b);
        logic [2047:0] t;
        t = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                t[(c*8+r)*32 +: 32] = b[(r*8+c)*32 +: 32];
        return t;
    endfunction

    // Stub array behaviour: 0 identity, 1 transposes internally, 2 lane-wise x*2+shift.
    function automatic logic [2047:0] stub_fn(input logic [2047:0] b, input logic [4:0] sh, input int mode);
        logic [2047:0] o;
        o = b;
        if (mode == 1) o = tr(b);
        if (mode == 2)
            for (int i = 0; i < 64; i++) o[i*32 +: 32] = b[i*32 +: 32] * 32'd2 + 32'(sh);
        return o;
    endfunction

    function automatic logic [2047:0] model(input logic [2047:0] x, input int mode);
        logic [2047:0] p1;
        p1 = tr(stub_fn(x, 5'(ROW), mode));
        return tr(stub_fn(p1, 5'(COL), mode));
    endfunction

    assign idct_done = (vpipe[L-1] & stub_en) | extra_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe   <= '0;
            issue_n <= 0;
        end else begin
            vpipe <= {vpipe[L-2:0], idct_valid};
            if (idct_valid) begin
                stub_res <= stub_fn(idct_data, idct_shift, stub_mode);
                shift_at[issue_n % 2] <= idct_shift;
                issue_n <= issue_n + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
        int bad;
        compared++;
        if (act !== exp) begin
            mismatched++;
            bad = 0;
            for (int i = 63; i >= 0; i--) if (act[i*32 +: 32] !== exp[i*32 +: 32]) bad = i;
            $display("FAIL %s: element %0d got %0h expected %0h", nm, bad,
                     act[bad*32 +: 32], exp[bad*32 +: 32]);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " s_ready"}, 32'(s_ready), 0);
        chk({nm, " m_valid"}, 32'(m_valid), 0);
        chk({nm, " idct_valid"}, 32'(idct_valid), 0);
        chk({nm, " err"}, 32'(err), 0);
        chk({nm, " idct_shift"}, 32'(idct_shift), ROW);
        chk_blk({nm, " m_data"}, m_data, '0);
        chk_blk({nm, " idct_data"}, idct_data, '0);
    endtask

    task automatic send_block(input vec_t v, input string nm);
        int n;
        int a;
        logic [2047:0] held;
        logic [2047:0] e;
        bit stable;
        stub_mode = v.mode;
        n = 0;
        while (!s_ready && n < 50) begin tick(); n++; end
        chk({nm, " s_ready before"}, 32'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = v.blk;
        exp_q.push_back(v.exp);
        tick();
        a = cyc;
        s_valid = 1'b0;
        if (v.inject) extra_done = 1'b1;
        chk({nm, " row issue strobe"}, 32'(idct_valid), 1);
        chk({nm, " s_ready busy"}, 32'(s_ready), 0);
        tick();
        extra_done = 1'b0;
        n = 0;
        while (!m_valid && n < 100) begin tick(); n++; end
        chk({nm, " latency"}, 32'(cyc - a + 1), 32'(3 + 2*L));
        e = exp_q.pop_front();
        chk_blk({nm, " data"}, m_data, e);
        chk({nm, " row shift"}, 32'(shift_at[0]), ROW);
        chk({nm, " col shift"}, 32'(shift_at[1]), COL);
        held = m_data;
        stable = 1'b1;
        for (int d = 0; d < v.delay; d++) begin
            if (m_data !== held || s_ready !== 1'b0 || m_valid !== 1'b1) stable = 1'b0;
            tick();
        end
        if (v.delay > 0) chk({nm, " hold stable"}, 32'(stable), 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk({nm, " s_ready after"}, 32'(s_ready), 1);
        chk({nm, " m_valid after"}, 32'(m_valid), 0);
    endtask

    initial begin
        vec_t v;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                vecs[0].blk[(r*8+c)*32 +: 32] = 32'(r*8 + c);
                vecs[2].blk[(r*8+c)*32 +: 32] = 32'(r);
                vecs[3].blk[(r*8+c)*32 +: 32] = $urandom;
            end
        vecs[1].blk = vecs[0].blk;
        vecs[4].blk = vecs[3].blk;
        vecs[0].mode = 0; vecs[0].delay = 0;  vecs[0].inject = 1'b0;
        vecs[1].mode = 0; vecs[1].delay = 10; vecs[1].inject = 1'b0;
        vecs[2].mode = 1; vecs[2].delay = 0;  vecs[2].inject = 1'b0;
        vecs[3].mode = 2; vecs[3].delay = 2;  vecs[3].inject = 1'b0;
        vecs[4].mode = 0; vecs[4].delay = 0;  vecs[4].inject = 1'b1;
        for (int i = 0; i < 5; i++) vecs[i].exp = model(vecs[i].blk, vecs[i].mode);

        // Reset state
        tick(); tick();
        chk_reset_vals("reset");
        rst = 1'b1;
        tick();
        chk("s_ready after release", 32'(s_ready), 1);

        // Stray done in IDLE
        extra_done = 1'b1;
        tick();
        extra_done = 1'b0;
        tick();
        chk("idle done s_ready", 32'(s_ready), 1);
        chk("idle done m_valid", 32'(m_valid), 0);
        chk("idle done idct_valid", 32'(idct_valid), 0);

        for (int i = 0; i < 5; i++) send_block(vecs[i], $sformatf("vec%0d", i));

        // Reset during ROW_WAIT aborts the block
        stub_mode = 0;
        s_valid = 1'b1;
        s_data  = vecs[3].blk;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_reset_vals("abort");
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("abort s_ready", 32'(s_ready), 1);
        chk("abort m_valid", 32'(m_valid), 0);
        v = vecs[0];
        send_block(v, "post-abort");

`ifdef IDCT_SEQ_WATCHDOG_EN
        begin
            int a;
            int n;
            bit mv_seen;
            stub_en = 1'b0;
            s_valid = 1'b1;
            s_data  = vecs[0].blk;
            tick();
            a = cyc;
            s_valid = 1'b0;
            n = 0;
            mv_seen = 1'b0;
            while (!err && n < 60) begin
                if (m_valid) mv_seen = 1'b1;
                tick();
                n++;
            end
            chk("wd err set", 32'(err), 1);
            compared++;
            if ((cyc - a) < 19 || (cyc - a) > 24) begin
                mismatched++;
                $display("FAIL wd timing: got %0d cycles after row issue expected about 21", cyc - a);
            end
            chk("wd back to idle", 32'(s_ready), 1);
            chk("wd no m_valid", 32'(mv_seen | m_valid), 0);
            tick(); tick(); tick();
            chk("wd err sticky", 32'(err), 1);
            chk("wd still no m_valid", 32'(m_valid), 0);
            rst = 1'b0;
            #1;
            chk("wd err cleared", 32'(err), 0);
            tick();
            rst = 1'b1;
            stub_en = 1'b1;
            tick();
        end
`else
        chk("err tied low", 32'(err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
